bitmap_stream_writer: RTL and testbench

//  Accepts a row-major 8-bit RGB pixel stream (valid/ready) and writes it into an internal sprite RAM.

---
 rtl/bitmap_pkg.sv | 11 +
 rtl/bitmap_dp_ram.sv | 24 ++
 rtl/bitmap_stream_writer.sv | 139 +++++++++++++
 tb/tb_bitmap_stream_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared types and default encodings for the sprite-bitmap write path.
package bitmap_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} writer_state_t;

  localparam pixel_t TRANSPARENT_ENCODING_DEF = 8'hFF;
  localparam pixel_t CHROMA_KEY_DEF           = 8'hFE;

endpackage

// File: rtl/bitmap_dp_ram.sv
// Simple dual-port sprite RAM: one write port, one registered read port.
// Read and write of the same address in one cycle return the old contents.
module bitmap_dp_ram
  import bitmap_pkg::*;
#(
  parameter int DEPTH = 676,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pixel_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pixel_t        o_rdata
);

  pixel_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/bitmap_stream_writer.sv
// Loads a row-major RGB332 pixel stream into the sprite RAM and serves registered reads.
// Define BITMAP_WRITER_CHROMA_EN to store CHROMA_KEY pixels as TRANSPARENT_ENCODING.
module bitmap_stream_writer
  import bitmap_pkg::*;
#(
  parameter int     OBJECT_WIDTH_X       = 26,
  parameter int     OBJECT_HEIGHT_Y      = 26,
  parameter pixel_t TRANSPARENT_ENCODING = TRANSPARENT_ENCODING_DEF,
  parameter pixel_t CHROMA_KEY           = CHROMA_KEY_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  pixel_t      i_pix_data,
  input  logic        i_pix_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_loaded,
  input  logic [10:0] i_rd_x,
  input  logic [10:0] i_rd_y,
  output pixel_t      o_rd_data
);

  localparam int DEPTH = OBJECT_WIDTH_X * OBJECT_HEIGHT_Y;
  localparam int AW    = $clog2(DEPTH);

  writer_state_t r_state;
  logic [10:0]   r_x, r_y;
  logic          r_pix_ready, r_busy, r_done, r_error, r_loaded, r_rd_hit;

  logic          w_xfer, w_we, w_at_end, w_rd_in;
  logic [AW-1:0] w_waddr, w_raddr, w_rd_lin;
  pixel_t        w_wdata, w_ram_q;

  assign w_xfer   = i_pix_valid && r_pix_ready;
  // a same-cycle start drops the transfer
  assign w_we     = (r_state == LOAD) && w_xfer && !i_start;
  assign w_at_end = (r_x == 11'(OBJECT_WIDTH_X - 1)) && (r_y == 11'(OBJECT_HEIGHT_Y - 1));
  assign w_waddr  = AW'(r_y) * AW'(OBJECT_WIDTH_X) + AW'(r_x);

`ifdef BITMAP_WRITER_CHROMA_EN
  assign w_wdata = (i_pix_data == CHROMA_KEY) ? TRANSPARENT_ENCODING : i_pix_data;
`else
  assign w_wdata = i_pix_data;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_state     <= LOAD;
        r_x         <= '0;
        r_y         <= '0;
        r_error     <= 1'b0;
        r_loaded    <= 1'b0;
        r_pix_ready <= 1'b1;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          IDLE: ;
          LOAD: begin
            if (w_xfer) begin
              if (w_at_end) begin
                if (i_pix_last) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_loaded    <= 1'b1;
                  r_pix_ready <= 1'b0;
                  r_busy      <= 1'b0;
                end else begin
                  r_state <= DRAIN;
                  r_error <= 1'b1;
                end
              end else if (i_pix_last) begin
                r_state     <= IDLE;
                r_error     <= 1'b1;
                r_pix_ready <= 1'b0;
                r_busy      <= 1'b0;
              end else if (r_x == 11'(OBJECT_WIDTH_X - 1)) begin
                r_x <= '0;
                r_y <= r_y + 11'd1;
              end else begin
                r_x <= r_x + 11'd1;
              end
            end
          end
          DRAIN: begin
            if (w_xfer && i_pix_last) begin
              r_state     <= IDLE;
              r_pix_ready <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          DONE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // out-of-range reads index address 0; the hit flag masks the data
  assign w_rd_in  = (i_rd_x < 11'(OBJECT_WIDTH_X)) && (i_rd_y < 11'(OBJECT_HEIGHT_Y));
  assign w_rd_lin = AW'(i_rd_y) * AW'(OBJECT_WIDTH_X) + AW'(i_rd_x);
  assign w_raddr  = w_rd_in ? w_rd_lin : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rd_hit <= 1'b0;
    else         r_rd_hit <= r_loaded && w_rd_in;
  end

  bitmap_dp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  assign o_pix_ready = r_pix_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_loaded    = r_loaded;
  assign o_rd_data   = r_rd_hit ? w_ram_q : TRANSPARENT_ENCODING;

endmodule

// File: tb/tb_bitmap_stream_writer.sv
// Self-checking bench for bitmap_stream_writer: frame loads, short/long frames, restart, reads.
module tb_bitmap_stream_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [7:0]  i_pix_data = 8'h00;
  logic        i_pix_last = 1'b0;
  logic [10:0] i_rd_x = '0;
  logic [10:0] i_rd_y = '0;
  logic        o_pix_ready, o_busy, o_done, o_error, o_loaded;
  logic [7:0]  o_rd_data;

  bitmap_stream_writer dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (i_start),
    .i_pix_valid (i_pix_valid),
    .o_pix_ready (o_pix_ready),
    .i_pix_data  (i_pix_data),
    .i_pix_last  (i_pix_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_loaded    (o_loaded),
    .i_rd_x      (i_rd_x),
    .i_rd_y      (i_rd_y),
    .o_rd_data   (o_rd_data)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] rd_q[$];

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_read(input string nm, input int x, input int y, input logic [7:0] exp);
    logic [7:0] e;
    i_rd_x = 11'(x);
    i_rd_y = 11'(y);
    rd_q.push_back(exp);
    tick();
    e = rd_q.pop_front();
    chk(nm, int'(o_rd_data), int'(e));
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] d, input logic l);
    int budget = 0;
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    i_pix_last  = l;
    while (o_pix_ready !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    if (o_pix_ready !== 1'b1) chk("ready_timeout", int'(o_pix_ready), 1);
    tick();
    i_pix_valid = 1'b0;
    i_pix_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [7:0] xr, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_px(8'(i) ^ xr, i == last_at);
    end
  endtask

  initial begin
    int base;
    tbl[0] = '{3, 1, 8'h1D};
    tbl[1] = '{0, 0, 8'h00};
    tbl[2] = '{25, 0, 8'h19};
    tbl[3] = '{0, 1, 8'h1A};
    tbl[4] = '{25, 25, 8'hA3};
    tbl[5] = '{10, 10, 8'h0E};
    tbl[6] = '{26, 0, 8'hFF};
    tbl[7] = '{0, 26, 8'hFF};
    tbl[8] = '{2047, 2047, 8'hFF};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 1: reset state
    chk("rst_ready",  int'(o_pix_ready), 0);
    chk("rst_busy",   int'(o_busy), 0);
    chk("rst_error",  int'(o_error), 0);
    chk("rst_loaded", int'(o_loaded), 0);
    do_read("rst_rd00", 0, 0, 8'hFF);

    // 2: full frame
    base = done_cnt;
    pulse_start();
    chk("load_busy",  int'(o_busy), 1);
    chk("load_ready", int'(o_pix_ready), 1);
    send_frame(676, 675, 8'h00, 1'b0);
    tick(); tick();
    chk("f2_done_cnt", done_cnt - base, 1);
    chk("f2_loaded",   int'(o_loaded), 1);
    chk("f2_error",    int'(o_error), 0);
    chk("f2_busy",     int'(o_busy), 0);
    for (int i = 0; i < 9; i++) do_read($sformatf("f2_rd_%0d", i), tbl[i].x, tbl[i].y, tbl[i].exp);

    // 3: short frame
    base = done_cnt;
    pulse_start();
    chk("f3_loaded_cleared", int'(o_loaded), 0);
    send_frame(11, 10, 8'h00, 1'b0);
    chk("f3_error",  int'(o_error), 1);
    chk("f3_ready",  int'(o_pix_ready), 0);
    chk("f3_busy",   int'(o_busy), 0);
    chk("f3_loaded", int'(o_loaded), 0);
    chk("f3_no_done", done_cnt - base, 0);
    do_read("f3_rd00", 0, 0, 8'hFF);
    pulse_start();
    chk("f3_err_clr", int'(o_error), 0);

    // 4: long frame, drained
    pulse_start();
    send_frame(676, -1, 8'h00, 1'b0);
    chk("f4_error_drain", int'(o_error), 1);
    chk("f4_ready_drain", int'(o_pix_ready), 1);
    chk("f4_busy_drain",  int'(o_busy), 1);
    send_px(8'h11, 1'b0);
    send_px(8'h22, 1'b0);
    send_px(8'h33, 1'b1);
    chk("f4_error_end", int'(o_error), 1);
    chk("f4_ready_end", int'(o_pix_ready), 0);
    chk("f4_loaded",    int'(o_loaded), 0);
    chk("f4_no_done",   done_cnt - base, 0);
    do_read("f4_rd00", 0, 0, 8'hFF);

    // 5: gaps with restart mid-frame; the transfer beside start is dropped
    pulse_start();
    send_frame(100, -1, 8'h00, 1'b1);
    i_pix_valid = 1'b1;
    i_pix_data  = 8'hAA;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
    i_pix_valid = 1'b0;
    chk("f5_loaded_restart", int'(o_loaded), 0);
    chk("f5_busy_restart",   int'(o_busy), 1);
    do_read("f5_rd_loading", 0, 0, 8'hFF);
    send_frame(676, 675, 8'h5A, 1'b1);
    tick(); tick();
    chk("f5_done_cnt", done_cnt - base, 1);
    chk("f5_loaded",   int'(o_loaded), 1);
    do_read("f5_rd00",   0, 0, 8'h5A);
    do_read("f5_rd31",   3, 1, 8'h47);
    do_read("f5_rd43",   4, 3, 8'h08);
    do_read("f5_rd2525", 25, 25, 8'hF9);

    // 6: chroma key at (5,5)
    pulse_start();
    for (int i = 0; i < 676; i++) send_px((i == 135) ? 8'hFE : 8'(i), i == 675);
    tick(); tick();
    chk("f6_loaded", int'(o_loaded), 1);
`ifdef BITMAP_WRITER_CHROMA_EN
    do_read("f6_rd55", 5, 5, 8'hFF);
`else
    do_read("f6_rd55", 5, 5, 8'hFE);
`endif
    do_read("f6_rd45",  4, 5, 8'h86);
    do_read("f6_rd260", 26, 0, 8'hFF);

    // reset mid-load
    pulse_start();
    send_frame(5, -1, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("rst_mid_busy",   int'(o_busy), 0);
    chk("rst_mid_loaded", int'(o_loaded), 0);
    tick();
    rst = 1'b0;
    do_read("rst_mid_rd", 3, 1, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
